pp_csa_accumulator: RTL

- Parametrised successor to the fixed two-beat, 32-bit partial-product adder in the vector multiplier datapath.
- Accepts unsigned LANE_W x LANE_W partial products from the base multiplier array over several beats, accumulates them in carry-save form, then resolves them in one carry-propagate add.
- Produces SIMD products for element widths 8/16/32/64 selected by sew.
- Adds a valid/ready handshake on both sides, a synchronous abort, and lane-boundary carry isolation.

---
 rtl/pp_csa_accumulator.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/pp_csa_accumulator.sv
// Multi-beat carry-save accumulator for SIMD partial products, resolved by one lane-isolated add.
// Operand and lane widths are assumed to be powers of two so chunk indexing reduces to shifts.
module pp_csa_accumulator #(
  parameter int OPW         = 32,
  parameter int LANE_W      = 8,
  parameter int PP_PER_BEAT = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [1:0]                      sew,
  input  logic [PP_PER_BEAT*2*LANE_W-1:0] pp,
  input  logic                            kill,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [2*OPW-1:0]                result,
  output logic                            sew_err
);

  localparam int RW      = 2 * OPW;
  localparam int PPW     = 2 * LANE_W;
  localparam int NCH     = OPW / LANE_W;
  localparam int NPP     = NCH * NCH;
  localparam int BEATS   = NPP / PP_PER_BEAT;
  localparam int LG_NCH  = $clog2(NCH);
  localparam int LG_LANE = $clog2(LANE_W);
  localparam int CW      = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int KW      = $clog2(NPP) + 1;
  localparam int SW      = $clog2(RW);
  localparam int LW      = $clog2(RW) + 2;
  localparam int NOP     = PP_PER_BEAT + 2;
  localparam int NCK     = RW / 16;

  // Operand count remaining after a given number of 3:2 compression levels.
  function automatic int ops_at(input int lvl);
    int n;
    n = NOP;
    for (int l = 0; l < lvl; l++) begin
      if (n > 2) n = 2 * (n / 3) + (n % 3);
    end
    return n;
  endfunction

  function automatic int num_lvls();
    int n;
    int l;
    n = NOP;
    l = 0;
    while (n > 2) begin
      n = 2 * (n / 3) + (n % 3);
      l++;
    end
    return l;
  endfunction

  localparam int NLVL = num_lvls();

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    RESOLVE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t          state_reg;
  state_t          state_next;
  logic [CW-1:0]   cnt_reg;
  logic [RW-1:0]   sum_reg;
  logic [RW-1:0]   carry_reg;
  logic [1:0]      sew_reg;

  logic            accept;
  logic            last_beat;
  logic            flush;
  logic [1:0]      sew_eff;
  logic [LW-1:0]   ew_bits;
  logic [LW-1:0]   lane_mod;
  logic [2:0]      lane_sh;
  logic            sew_bad;
  logic [RW-1:0]   lane_start;
  logic [RW-1:0]   sum_next;
  logic [RW-1:0]   carry_next;
  logic [RW-1:0]   final_sum;
  logic [RW-1:0]   tree [NLVL+1][NOP];

  // Beat 0 is compressed in the same cycle sew is latched, so use the live value in IDLE.
  assign sew_eff   = (state_reg == IDLE) ? sew : sew_reg;
  assign ew_bits   = LW'(8) << sew_eff;
  assign lane_mod  = (LW'(16) << sew_eff) - LW'(1);
  assign lane_sh   = 3'd3 + {1'b0, sew_eff} - 3'(LG_LANE);
  assign sew_bad   = (ew_bits > LW'(OPW)) || (ew_bits < LW'(LANE_W));
  assign last_beat = (cnt_reg == CW'(BEATS - 1));
  assign accept    = in_valid && in_ready && !kill;
  assign flush     = (kill && (state_reg != DONE)) || ((state_reg == DONE) && out_ready);

  for (genvar gi = 0; gi < RW; gi++) begin : g_lane_start
    assign lane_start[gi] = ~|(LW'(gi) & lane_mod);
  end

  assign tree[0][0] = (state_reg == IDLE) ? '0 : sum_reg;
  assign tree[0][1] = (state_reg == IDLE) ? '0 : carry_reg;

  for (genvar gi = 0; gi < PP_PER_BEAT; gi++) begin : g_slot
    logic [KW-1:0] k;
    logic [KW-1:0] row;
    logic [KW-1:0] col;
    logic [KW:0]   rc;
    logic          keep;

    assign k    = KW'(cnt_reg) * KW'(PP_PER_BEAT) + KW'(gi);
    assign row  = k >> LG_NCH;
    assign col  = k & KW'(NCH - 1);
    assign rc   = {1'b0, row} + {1'b0, col};
    assign keep = !sew_bad && ((row >> lane_sh) == (col >> lane_sh));
    assign tree[0][gi+2] = keep ? (RW'(pp[gi*PPW +: PPW]) << (SW'(rc) << LG_LANE)) : '0;
  end

  // Wallace-style reduction; carries crossing into a lane's lowest bit are discarded.
  for (genvar gl = 0; gl < NLVL; gl++) begin : g_lvl
    localparam int NIN  = ops_at(gl);
    localparam int NGRP = NIN / 3;
    localparam int NOUT = ops_at(gl + 1);
    for (genvar gi = 0; gi < NOP; gi++) begin : g_op
      if (gi < 2 * NGRP) begin : g_csa
        if (gi % 2 == 0) begin : g_sum
          assign tree[gl+1][gi] = tree[gl][3*(gi/2)] ^ tree[gl][3*(gi/2)+1] ^ tree[gl][3*(gi/2)+2];
        end else begin : g_carry
          assign tree[gl+1][gi] = (((tree[gl][3*(gi/2)]   & tree[gl][3*(gi/2)+1]) |
                                    (tree[gl][3*(gi/2)]   & tree[gl][3*(gi/2)+2]) |
                                    (tree[gl][3*(gi/2)+1] & tree[gl][3*(gi/2)+2])) << 1) & ~lane_start;
        end
      end else if (gi < NOUT) begin : g_pass
        assign tree[gl+1][gi] = tree[gl][NGRP + gi];
      end else begin : g_zero
        assign tree[gl+1][gi] = '0;
      end
    end
  end

  assign sum_next   = tree[NLVL][0];
  assign carry_next = tree[NLVL][1];

  // Final add in 16-bit chunks; every lane boundary falls on a chunk boundary.
  logic [NCK-1:0] fa_c;
  for (genvar gi = 0; gi < NCK; gi++) begin : g_fa
    logic cin;
    if (gi == 0) begin : g_first
      assign cin = 1'b0;
    end else begin : g_next
      assign cin = lane_start[gi*16] ? 1'b0 : fa_c[gi-1];
    end
    if (gi == NCK - 1) begin : g_top
      assign final_sum[gi*16 +: 16] = sum_reg[gi*16 +: 16] + carry_reg[gi*16 +: 16] + 16'(cin);
      assign fa_c[gi] = 1'b0;
    end else begin : g_mid
      assign {fa_c[gi], final_sum[gi*16 +: 16]} =
        {1'b0, sum_reg[gi*16 +: 16]} + {1'b0, carry_reg[gi*16 +: 16]} + 17'(cin);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    unique case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (accept) state_next = last_beat ? RESOLVE : ACCUM;
      end
      ACCUM: begin
        in_ready = 1'b1;
        if (accept && last_beat) state_next = RESOLVE;
      end
      RESOLVE: state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (kill && (state_reg != DONE)) state_next = IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_reg   <= '0;
      sum_reg   <= '0;
      carry_reg <= '0;
      sew_reg   <= '0;
      result    <= '0;
      out_valid <= 1'b0;
      sew_err   <= 1'b0;
    end else begin
      if (flush) begin
        cnt_reg   <= '0;
        sum_reg   <= '0;
        carry_reg <= '0;
      end else if (accept) begin
        sum_reg   <= sum_next;
        carry_reg <= carry_next;
        cnt_reg   <= last_beat ? '0 : cnt_reg + 1'b1;
        if (state_reg == IDLE) sew_reg <= sew;
      end
      if ((state_reg == RESOLVE) && !kill) begin
        result    <= sew_bad ? '0 : final_sum;
        out_valid <= 1'b1;
        sew_err   <= sew_bad;
      end else if ((state_reg == DONE) && out_ready) begin
        out_valid <= 1'b0;
        sew_err   <= 1'b0;
      end
    end
  end

endmodule
